// File: rtl/freq_cmp_pkg.sv
// freq_cmp_pkg
//   Shared types and constants for the reference-clock side of the
//   two-domain frequency comparator.
//   - fcmp_state_t       : initiator FSM state encoding
//   - FCMP_SETTLE_CYCLES : default settle delay after timer_done
package freq_cmp_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNT     = 3'd1,
    WAIT_DONE = 3'd2,
    SETTLE    = 3'd3,
    REPORT    = 3'd4
  } fcmp_state_t;

  localparam int FCMP_SETTLE_CYCLES = 4;

endpackage

// File: rtl/freq_cmp_wdog.sv
// freq_cmp_wdog
//   Handshake watchdog: a clear/run counter that flags expiry on the cycle
//   whose increment would bring the count to all-ones. The owner therefore
//   sees exactly 2**WDOG_WIDTH-1 run cycles before acting on expire.
// Ports:
//   clk     in  clock
//   reset_n in  asynchronous active-low reset
//   clear   in  synchronous clear (dominates run)
//   run     in  count enable
//   expire  out high when this run cycle completes the full timeout
module freq_cmp_wdog #(
  parameter int WDOG_WIDTH = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = {{(WDOG_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WDOG_WIDTH-1:0] WDOG_MAX  = {WDOG_WIDTH{1'b1}};

  logic [WDOG_WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (run && (count_reg != WDOG_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = run & ~clear & (count_reg == WDOG_LAST);

endmodule

// File: rtl/freq_compare_initiator.sv
// freq_compare_initiator
//   Reference-clock-side initiator of the count_enable / timer_done
//   handshake. Opens a window of timeout_value clk cycles, waits for the
//   remote counter's synchronized timer_done, lets the remote count settle,
//   then reports whether that count is >= the local window length.
// Ports:
//   clk             in  reference clock
//   reset_n         in  asynchronous active-low reset
//   enable          in  start request, rising edge starts a measurement
//   timeout_value   in  window length, captured at start
//   timer_done      in  remote window-closed flag (already synchronized)
//   timeout_compare in  remote count, quasi-static once timer_done is high
//   count_enable    out window qualifier to the remote domain (registered)
//   timeout_count   out local window counter
//   compare_ge      out timeout_compare >= captured window length
//   compare_done    out one-cycle result-valid pulse
//   busy            out high whenever not IDLE
//   error           out sticky until next start: zero window or watchdog
module freq_compare_initiator
  import freq_cmp_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = FCMP_SETTLE_CYCLES,
  parameter int WDOG_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] timeout_value,
  input  logic                  timer_done,
  input  logic [DATA_WIDTH-1:0] timeout_compare,
  output logic                  count_enable,
  output logic [DATA_WIDTH-1:0] timeout_count,
  output logic                  compare_ge,
  output logic                  compare_done,
  output logic                  busy,
  output logic                  error
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  fcmp_state_t state_reg, state_next;

  logic                  enable_d_reg;
  logic [DATA_WIDTH-1:0] win_len_reg;
  logic [DATA_WIDTH-1:0] timeout_count_reg;
  logic                  count_enable_reg;
  logic                  compare_ge_reg;
  logic                  error_reg;
  logic                  seen_low_reg;
  logic [SETTLE_W-1:0]   settle_cnt_reg;

  logic start;
  logic zero_window;
  logic window_last;
  logic done_ok;
  logic settle_last;
  logic wdog_clear;
  logic wdog_run;
  logic wdog_expire;

  assign start       = enable & ~enable_d_reg & (state_reg == IDLE);
  assign zero_window = (timeout_value == '0);
  assign window_last = (timeout_count_reg == win_len_reg - 1'b1);
  // seen_low rejects a timer_done still high from the previous run.
  assign done_ok     = seen_low_reg & timer_done;
  assign settle_last = (settle_cnt_reg == SETTLE_LAST);

  // Watchdog is held clear outside WAIT_DONE, so it starts at zero on entry.
  assign wdog_clear = (state_reg != WAIT_DONE);
  assign wdog_run   = (state_reg == WAIT_DONE);

  freq_cmp_wdog #(
    .WDOG_WIDTH(WDOG_WIDTH)
  ) u_wdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (wdog_clear),
    .run    (wdog_run),
    .expire (wdog_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = zero_window ? REPORT : COUNT;
        end
      end
      COUNT: begin
        if (window_last) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A valid done in the same cycle as expiry wins.
        if (done_ok) begin
          state_next = SETTLE;
        end else if (wdog_expire) begin
          state_next = REPORT;
        end
      end
      SETTLE: begin
        if (settle_last) begin
          state_next = REPORT;
        end
      end
      REPORT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_d_reg      <= 1'b0;
      win_len_reg       <= '0;
      timeout_count_reg <= '0;
      count_enable_reg  <= 1'b0;
      compare_ge_reg    <= 1'b0;
      error_reg         <= 1'b0;
      seen_low_reg      <= 1'b0;
      settle_cnt_reg    <= '0;
    end else begin
      enable_d_reg <= enable;
      case (state_reg)
        IDLE: begin
          if (start) begin
            win_len_reg       <= timeout_value;
            timeout_count_reg <= '0;
            compare_ge_reg    <= 1'b0;
            error_reg         <= zero_window;
            seen_low_reg      <= 1'b0;
            count_enable_reg  <= ~zero_window;
          end
        end
        COUNT: begin
          timeout_count_reg <= timeout_count_reg + 1'b1;
          if (!timer_done) begin
            seen_low_reg <= 1'b1;
          end
          if (window_last) begin
            count_enable_reg <= 1'b0;
          end
        end
        WAIT_DONE: begin
          settle_cnt_reg <= '0;
          if (!timer_done) begin
            seen_low_reg <= 1'b1;
          end
          if (!done_ok && wdog_expire) begin
            error_reg <= 1'b1;
          end
        end
        SETTLE: begin
          settle_cnt_reg <= settle_cnt_reg + 1'b1;
          if (settle_last) begin
            compare_ge_reg <= (timeout_compare >= win_len_reg);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign count_enable  = count_enable_reg;
  assign timeout_count = timeout_count_reg;
  assign compare_ge    = compare_ge_reg;
  assign error         = error_reg;
  assign compare_done  = (state_reg == REPORT);
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_freq_compare_initiator.sv
module tb_freq_compare_initiator;

  localparam int DW = 32;
  localparam int WW = 4;
  localparam int SC = 4;
  localparam int WDOG_CYCLES = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] timeout_value = '0;
  logic          timer_done = 1'b0;
  logic [DW-1:0] timeout_compare = '0;
  logic          count_enable;
  logic [DW-1:0] timeout_count;
  logic          compare_ge;
  logic          compare_done;
  logic          busy;
  logic          error;

  int checks = 0;
  int errors = 0;

  freq_compare_initiator #(
    .DATA_WIDTH   (DW),
    .SETTLE_CYCLES(SC),
    .WDOG_WIDTH   (WW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .timeout_value  (timeout_value),
    .timer_done     (timer_done),
    .timeout_compare(timeout_compare),
    .count_enable   (count_enable),
    .timeout_count  (timeout_count),
    .compare_ge     (compare_ge),
    .compare_done   (compare_done),
    .busy           (busy),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One measurement. The remote side is modelled here: it counts the
  // cycles count_enable is high, publishes that count plus an offset when
  // count_enable falls, and raises timer_done ddly cycles later.
  // Cycle n is the n-th falling edge after the one where enable rose.
  task automatic run_meas(input string name, input int win, input int extra, input int ddly,
                          input bit stale, input bit stuck, input bit retoggle);
    int  n, rise_cyc, fall_cyc, drive_cyc, cd_cyc, ce_hi, pulses, exp_cd;
    longint tcv;
    bit  prev_ce, exp_ge, exp_err;
    logic [31:0] got_ge, got_err, got_tc;
    n = 0; rise_cyc = -1; fall_cyc = -1; drive_cyc = -1; cd_cyc = -1;
    ce_hi = 0; pulses = 0; prev_ce = 1'b0;
    got_ge = '0; got_err = '0; got_tc = '0;
    tcv = longint'(timeout_compare);
    @(negedge clk);
    timeout_value = DW'(win);
    enable = 1'b1;
    if (stale) timer_done = 1'b1;
    while (n < 400 && !(cd_cyc >= 0 && n > cd_cyc + 1)) begin
      @(negedge clk);
      n++;
      if (n == 3) enable = 1'b0;
      if (retoggle && n == 5) enable = 1'b1;
      if (n == 1) check({name, "_busy"}, busy, 1);
      if (count_enable) ce_hi++;
      if (count_enable && !prev_ce) begin
        rise_cyc = n;
        if (!stale) timer_done = 1'b0;
      end
      if (!count_enable && prev_ce) begin
        fall_cyc = n;
        tcv = longint'(ce_hi) + longint'(extra);
        if (tcv < 0) tcv = 0;
        timeout_compare = DW'(tcv);
      end
      if (stale && rise_cyc >= 0 && n == rise_cyc + 3) timer_done = 1'b0;
      if (!stuck && fall_cyc >= 0 && n == fall_cyc + ddly) begin
        timer_done = 1'b1;
        drive_cyc = n;
      end
      prev_ce = count_enable;
      if (compare_done) begin
        pulses++;
        if (cd_cyc < 0) begin
          cd_cyc = n;
          got_ge = 32'(compare_ge);
          got_err = 32'(error);
          got_tc = timeout_count;
        end
      end
      if (cd_cyc >= 0 && n == cd_cyc + 1) check({name, "_busy_drop"}, busy, 0);
    end
    enable = 1'b0;
    check({name, "_ce_cycles"}, ce_hi, win);
    if (win > 0) check({name, "_ce_rise"}, rise_cyc, 1);
    if (cd_cyc < 0) begin
      check({name, "_done_timeout"}, 0, 1);
    end else begin
      exp_err = stuck || (win == 0);
      exp_ge  = !exp_err && (tcv >= longint'(win));
      if (win == 0)  exp_cd = 1;
      else if (stuck) exp_cd = fall_cyc + WDOG_CYCLES;
      else           exp_cd = drive_cyc + SC + 1;
      check({name, "_pulses"}, pulses, 1);
      check({name, "_latency"}, cd_cyc, exp_cd);
      check({name, "_ge"}, got_ge, 32'(exp_ge));
      check({name, "_err"}, got_err, 32'(exp_err));
      check({name, "_tcount"}, got_tc, win);
    end
    @(negedge clk);
  endtask

  task automatic reset_midrun();
    @(negedge clk);
    timeout_value = 50;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("rst_ce", count_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_tcount", timeout_count, 0);
    check("rst_done", compare_done, 0);
    check("rst_err", error, 0);
    check("rst_ge", compare_ge, 0);
    @(negedge clk);
    enable = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ce", count_enable, 0);
    check("reset_busy", busy, 0);
    check("reset_done", compare_done, 0);
    check("reset_tcount", timeout_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_meas("basic", 100, 0, 3, 1'b0, 1'b0, 1'b0);
    run_meas("slow", 100, -1, 3, 1'b0, 1'b0, 1'b0);
    run_meas("stale", 2, 0, 3, 1'b1, 1'b0, 1'b0);
    run_meas("zero", 0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_meas("wdog", 5, 0, 1, 1'b0, 1'b1, 1'b0);
    reset_midrun();
    run_meas("retoggle", 20, 1, 2, 1'b0, 1'b0, 1'b1);
    run_meas("clean", 7, 0, 2, 1'b0, 1'b0, 1'b0);
    run_meas("one", 1, 0, 1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_meas("rand", int'($urandom_range(1, 40)), int'($urandom_range(0, 6)) - 3,
               int'($urandom_range(1, 8)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
